generic_sub_pipe: RTL

Two-stage pipelined, enable-gated subtractor for the datapath cores: computes D = A − B with borrow and zero flags under a valid/ready handshake. It is the inverse-direction companion to the enable-gated combinational adder. It undoes offsets or produces differences, such as window sums minus outgoing samples. Operands are split into low/high halves so the borrow chain is cut by a register, and the block is fully throughput-1 with backpressure.

---
 rtl/generic_sub_pkg.sv | 13 +
 rtl/generic_sub_slice.sv | 20 ++
 rtl/generic_sub_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/generic_sub_pkg.sv
// Shared width constants for the subtractor/adder datapath cores.
// The low-half split rule lives here so every core cuts its carry/borrow chain at the same point.
package generic_sub_pkg;

    localparam int DEF_AW = 21;
    localparam int DEF_BW = 21;
    localparam int DEF_DW = 22;

    function automatic int lw_of(input int dw);
        return dw / 2;
    endfunction

endpackage

// File: rtl/generic_sub_slice.sv
// Combinational W-bit subtract slice with borrow in/out.
// The top instantiates one slice per pipeline half.
module generic_sub_slice #(
    parameter int W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic [W-1:0] d,
    output logic         borrow_out
);

    logic [W:0] full;

    // The extra top bit is set exactly when a - b - borrow_in goes negative.
    assign full       = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
    assign d          = full[W-1:0];
    assign borrow_out = full[W];

endmodule

// File: rtl/generic_sub_pipe.sv
// Two-stage enable-gated subtractor D = A - B with borrow/zero flags and valid/ready flow control.
// Stage 1 resolves the low half; stage 2 finishes the high half using the registered low borrow.
module generic_sub_pipe
    import generic_sub_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int BW = DEF_BW,
    parameter int DW = DEF_DW,
    parameter int LW = lw_of(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_a,
    input  logic [BW-1:0] in_b,
    input  logic          in_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_diff,
    output logic          out_borrow,
    output logic          out_zero
);

    localparam int HW = DW - LW;

    logic [DW-1:0] a_ext, b_ext, a_g, b_g;
    logic [LW-1:0] lo_d;
    logic          lo_b;
    logic [HW-1:0] hi_d;
    logic          hi_b;

    logic          s1_valid;
    logic [LW-1:0] s1_dlo;
    logic          s1_bl;
    logic [HW-1:0] s1_ahi, s1_bhi;
    logic          s1_en;

    logic          s2_adv, s1_adv, accept;
    logic [DW-1:0] s2_diff;

    assign a_ext = DW'(in_a);
    assign b_ext = DW'(in_b);
    // Disabled pairs enter as 0 - 0 so the result is naturally 0 with no borrow.
    assign a_g   = in_en ? a_ext : '0;
    assign b_g   = in_en ? b_ext : '0;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    generic_sub_slice #(.W(LW)) u_lo (
        .a          (a_g[LW-1:0]),
        .b          (b_g[LW-1:0]),
        .borrow_in  (1'b0),
        .d          (lo_d),
        .borrow_out (lo_b)
    );

    generic_sub_slice #(.W(HW)) u_hi (
        .a          (s1_ahi),
        .b          (s1_bhi),
        .borrow_in  (s1_bl),
        .d          (hi_d),
        .borrow_out (hi_b)
    );

    assign s2_diff = {hi_d, s1_dlo};

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_dlo   <= '0;
            s1_bl    <= 1'b0;
            s1_ahi   <= '0;
            s1_bhi   <= '0;
            s1_en    <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_dlo   <= lo_d;
                s1_bl    <= lo_b;
                s1_ahi   <= a_g[DW-1:LW];
                s1_bhi   <= b_g[DW-1:LW];
                s1_en    <= in_en;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
            out_zero   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_diff   <= s2_diff;
                out_borrow <= hi_b && s1_en;
                out_zero   <= (s2_diff == '0);
            end
        end
    end

endmodule
